// File: rtl/sram_if_pkg.sv
// Shared definitions for the sram requester: FSM states, grant ids, address width.
package sram_if_pkg;

  localparam int ADDR_W_DEF = 25;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    GAP
  } state_t;

  typedef logic grant_t;

  localparam grant_t GNT_VID = 1'b0;
  localparam grant_t GNT_CPU = 1'b1;

endpackage

// File: rtl/sram_requester_if.sv
// Edge-triggered sram request bus: strobes, address, write data, mode, read data, ready.
interface sram_requester_if #(
  parameter int ADDR_W = sram_if_pkg::ADDR_W_DEF
);
  logic [ADDR_W-1:0] addr;
  logic [7:0]        din;
  logic              rd;
  logic              we;
  logic              mode32;
  logic [31:0]       dout;
  logic              ready;

  modport master (
    output addr, din, rd, we, mode32,
    input  dout, ready
  );

  modport slave (
    input  addr, din, rd, we, mode32,
    output dout, ready
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter between the video and CPU ports.
// The pointer names the port that wins a tie; it moves to the other port after
// every completed grant and starts out favouring video.
module sram_rr_arbiter
  import sram_if_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   done,
  input  grant_t done_grant,
  output grant_t grant
);

  grant_t ptr;

  // Tie goes to the pointer, otherwise the lone requester wins.
  always_comb begin
    grant = GNT_VID;
    if (vid_req && cpu_req) grant = ptr;
    else if (cpu_req)       grant = GNT_CPU;
  end

  // Pointer moves away from whichever port just completed.
  always_ff @(posedge clk) begin
    if (rst)       ptr <= GNT_VID;
    else if (done) ptr <= (done_grant == GNT_VID) ? GNT_CPU : GNT_VID;
  end

endmodule

// File: rtl/sram_requester.sv
// Initiator for the edge-triggered sram: arbitrates a 32-bit video read port and
// an 8-bit CPU read/write port, generates clean strobe edges with a guaranteed
// low gap, holds addr/din/mode32 until data time, and returns data with 1-cycle acks.
module sram_requester
  import sram_if_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int READY_TIMEOUT = 64,
  parameter int MIN_GAP       = 2
) (
  input  logic              clk_sdram,
  input  logic              init,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [31:0]       vid_data,
  input  logic              cpu_rd,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  sram_requester_if.master  ram,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_MAX = (READY_TIMEOUT > MIN_GAP) ? READY_TIMEOUT : MIN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t TO_LAST  = cnt_t'(READY_TIMEOUT - 1);
  localparam cnt_t GAP_LAST = cnt_t'(MIN_GAP - 1);

  state_t            state, state_nxt;
  cnt_t              cnt, cnt_nxt;
  logic              is_write, is_write_nxt;
  grant_t            grant_q, grant_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic [7:0]        din_r, din_nxt;
  logic              rd_r, rd_nxt;
  logic              we_r, we_nxt;
  logic              mode32_r, mode32_nxt;
  logic              vid_ack_nxt, cpu_ack_nxt;
  logic [31:0]       vid_data_nxt;
  logic [7:0]        cpu_dout_nxt;
  logic              timeout_err_nxt;
  logic              done;
  logic              cpu_req;
  grant_t            arb_grant;

  assign cpu_req = cpu_rd | cpu_we;

  assign ram.addr   = addr_r;
  assign ram.din    = din_r;
  assign ram.rd     = rd_r;
  assign ram.we     = we_r;
  assign ram.mode32 = mode32_r;

  sram_rr_arbiter arb (
    .clk        (clk_sdram),
    .rst        (init),
    .vid_req    (vid_req),
    .cpu_req    (cpu_req),
    .done       (done),
    .done_grant (grant_q),
    .grant      (arb_grant)
  );

  // Next-state and next-output logic; every output is a register loaded from here.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    is_write_nxt    = is_write;
    grant_nxt       = grant_q;
    addr_nxt        = addr_r;
    din_nxt         = din_r;
    rd_nxt          = rd_r;
    we_nxt          = we_r;
    mode32_nxt      = mode32_r;
    vid_ack_nxt     = 1'b0;
    vid_data_nxt    = vid_data;
    cpu_ack_nxt     = 1'b0;
    cpu_dout_nxt    = cpu_dout;
    timeout_err_nxt = timeout_err;
    done            = 1'b0;

    case (state)
      IDLE: begin
        // sram holds ready low during its startup; nothing may be issued then.
        if ((vid_req || cpu_req) && ram.ready) begin
          grant_nxt    = arb_grant;
          // Both CPU strobes high counts as a write.
          is_write_nxt = (arb_grant == GNT_CPU) && cpu_we;
          addr_nxt     = (arb_grant == GNT_VID) ? vid_addr : cpu_addr;
          din_nxt      = cpu_din;
          // mode32 settles before the strobe and stays put until data time.
          mode32_nxt   = (arb_grant == GNT_VID);
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        rd_nxt    = !is_write;
        we_nxt    = is_write;
        cnt_nxt   = '0;
        state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!ram.ready) begin
          state_nxt = WAIT_HI;
        end else if (cnt == TO_LAST) begin
          // sram never acknowledged the edge: abandon without an ack so the
          // still-pending request is re-arbitrated after the gap.
          rd_nxt          = 1'b0;
          we_nxt          = 1'b0;
          timeout_err_nxt = 1'b1;
          cnt_nxt         = '0;
          state_nxt       = GAP;
        end else begin
          cnt_nxt = cnt + cnt_t'(1);
        end
      end
      WAIT_HI: begin
        if (ram.ready) begin
          if (grant_q == GNT_VID) begin
            vid_ack_nxt  = 1'b1;
            vid_data_nxt = ram.dout;
          end else begin
            cpu_ack_nxt = 1'b1;
            if (!is_write) cpu_dout_nxt = ram.dout[7:0];
          end
          rd_nxt    = 1'b0;
          we_nxt    = 1'b0;
          done      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_nxt = IDLE;
        else                 cnt_nxt   = cnt + cnt_t'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; init clears everything, dropping any strobe in flight.
  always_ff @(posedge clk_sdram) begin
    if (init) begin
      state       <= IDLE;
      cnt         <= '0;
      is_write    <= 1'b0;
      grant_q     <= GNT_VID;
      addr_r      <= '0;
      din_r       <= '0;
      rd_r        <= 1'b0;
      we_r        <= 1'b0;
      mode32_r    <= 1'b0;
      vid_ack     <= 1'b0;
      vid_data    <= '0;
      cpu_ack     <= 1'b0;
      cpu_dout    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      is_write    <= is_write_nxt;
      grant_q     <= grant_nxt;
      addr_r      <= addr_nxt;
      din_r       <= din_nxt;
      rd_r        <= rd_nxt;
      we_r        <= we_nxt;
      mode32_r    <= mode32_nxt;
      vid_ack     <= vid_ack_nxt;
      vid_data    <= vid_data_nxt;
      cpu_ack     <= cpu_ack_nxt;
      cpu_dout    <= cpu_dout_nxt;
      busy        <= (state_nxt != IDLE);
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule
